vec_demux_router: RTL and testbench
===================================

VEC_DEMUX_ROUTER -- requirements
Module: vec_demux_router

Interface
REQ-001 Parameter N, default 8, bits per vector lane.
REQ-002 Parameter M, default 16, lanes per vector.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  source presents a vector.
REQ-006 in_ready  output  1  router accepts the vector this cycle.
REQ-007 in_data  input  [M-1:0][N-1:0]  vector operand.
REQ-008 in_sel  input  2  destination: 00 port A, 01 port B, 10 port C, 11 discard.
REQ-009 a_valid, b_valid, c_valid  output  1 each  port holds a vector.
REQ-010 a_ready, b_ready, c_ready  input  1 each  sink consumes this cycle.
REQ-011 a_data, b_data, c_data  output  [M-1:0][N-1:0] each  port vector.
REQ-012 drop_cnt  output  8  count of vectors accepted with in_sel=11.

Function
REQ-013 Each port SHALL own a one-entry slot with two states, EMPTY and FULL.
REQ-014 Accept SHALL occur when in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 when in_sel=11, or when the selected slot is EMPTY, or when it is FULL and its ready is 1.
REQ-016 in_ready SHALL depend only on in_sel, slot state and port ready; it SHALL NOT depend on in_valid.
REQ-017 On accept to port X, slot X SHALL load in_data and be FULL in the next cycle; latency is 1 cycle.
REQ-018 FULL slot with ready=1 and no new load SHALL become EMPTY.
REQ-019 FULL slot with ready=1 and a simultaneous load SHALL stay FULL with the new data, giving back-to-back throughput of 1 vector/cycle.
REQ-020 FULL slot with ready=0 SHALL hold its data and valid stable.
REQ-021 x_valid SHALL equal slot X FULL; x_data SHALL be the slot contents. x_data is don't-care while EMPTY, but SHALL hold its last value.
REQ-022 Slots are independent: a stall on one port SHALL NOT block accepts routed to another port.
REQ-023 Accept with in_sel=11 SHALL leave all slots unchanged and increment drop_cnt, saturating at 255.
REQ-024 Vectors to one port SHALL leave that port in acceptance order; no reordering or duplication.
REQ-025 Lanes SHALL pass unmodified; there is no per-lane arithmetic.

Reset
REQ-026 When rst=1 at a clock edge, all slots SHALL become EMPTY, all slot data SHALL clear to 0, and drop_cnt SHALL clear to 0.
REQ-027 While rst=1, in_ready SHALL be 0 and no accept SHALL occur.
REQ-028 Reset mid-transfer SHALL discard held vectors without emitting them.
REQ-029 The first accept SHALL be possible in the cycle after rst falls.

Structure
REQ-030 A shared package SHALL hold the lane-width and lane-count defaults, a vector typedef, and a 2-bit destination enum (DST_A, DST_B, DST_C, DST_DROP).
REQ-031 The one-entry slot SHALL be a sub-module, vec_out_slot, parameterised by N and M and instantiated three times.
REQ-032 Routing decode and drop_cnt SHALL live in vec_demux_router.

Verification
REQ-033 After reset, drive in_valid=1, sel=00, data lane0=0x11, a_ready=1 -> next cycle a_valid=1, a_data lane0=0x11; b_valid=0 and c_valid=0.
REQ-034 Hold b_ready=0 and send two vectors to B -> first accepted; in_ready=0 for the second until b_ready=1; then B emits in order.
REQ-035 Stall A (a_ready=0, slot FULL) and send to C -> accepted immediately; c_valid=1 next cycle.
REQ-036 Send 260 vectors with sel=11 -> all accepted at 1/cycle; drop_cnt=255; no port valid.
REQ-037 Stream 8 vectors to B with b_ready=1 -> 8 consecutive b_valid cycles with data in order.
REQ-038 Assert rst while A and C are FULL -> next cycle a_valid=0, c_valid=0, drop_cnt=0, in_ready=0 until rst falls.

Source files
------------

// File: rtl/vec_demux_router_pkg.sv
// Shared types for the vector demux router.
// Lane geometry defaults, vector type, destination codes.
package vec_demux_router_pkg;
   localparam int LANE_W = 8;
   localparam int LANES  = 16;

   typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

   typedef enum logic [1:0] {
      DST_A    = 2'b00,
      DST_B    = 2'b01,
      DST_C    = 2'b10,
      DST_DROP = 2'b11
   } dst_e;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_e;
endpackage

// File: rtl/vec_demux_router_if.sv
// Source and three sink handshakes of the router.
// The router takes the slave view, the driver the master view.
interface vec_demux_router_if #(
   parameter int N = 8,
   parameter int M = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [M-1:0][N-1:0] in_data;
   logic [1:0]          in_sel;
   logic                a_valid;
   logic                b_valid;
   logic                c_valid;
   logic                a_ready;
   logic                b_ready;
   logic                c_ready;
   logic [M-1:0][N-1:0] a_data;
   logic [M-1:0][N-1:0] b_data;
   logic [M-1:0][N-1:0] c_data;
   logic [7:0]          drop_cnt;

   modport master (
      output in_valid, in_data, in_sel,
      output a_ready, b_ready, c_ready,
      input  in_ready, drop_cnt,
      input  a_valid, b_valid, c_valid,
      input  a_data, b_data, c_data
   );

   modport slave (
      input  in_valid, in_data, in_sel,
      input  a_ready, b_ready, c_ready,
      output in_ready, drop_cnt,
      output a_valid, b_valid, c_valid,
      output a_data, b_data, c_data
   );
endinterface

// File: rtl/vec_out_slot.sv
// One-entry output slot: EMPTY/FULL with held data.
// Caller only asserts load when the slot can take it.
module vec_out_slot
   import vec_demux_router_pkg::*;
#(
   parameter int N = LANE_W,
   parameter int M = LANES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                ready,
   input  logic [M-1:0][N-1:0] data,
   output logic                valid,
   output logic [M-1:0][N-1:0] q
);
   slot_e state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         q     <= '0;
      end else if (load) begin
         state <= FULL;
         q     <= data;
      end else if (ready) begin
         state <= EMPTY;
      end
   end

   assign valid = (state == FULL);
endmodule

// File: rtl/vec_demux_router.sv
// Routes each accepted vector to slot A, B, C or drops it.
// Each slot is independent so one stalled sink never blocks the others.
module vec_demux_router
   import vec_demux_router_pkg::*;
#(
   parameter int N = LANE_W,
   parameter int M = LANES
) (
   input logic           clk,
   input logic           rst,
   vec_demux_router_if.slave bus
);
   dst_e       sel;
   logic       open;
   logic       accept;
   logic [2:0] load;
   logic [7:0] drops;

   assign sel = dst_e'(bus.in_sel);

   always_comb begin
      open = 1'b0;
      unique case (sel)
         DST_A:    open = !bus.a_valid || bus.a_ready;
         DST_B:    open = !bus.b_valid || bus.b_ready;
         DST_C:    open = !bus.c_valid || bus.c_ready;
         DST_DROP: open = 1'b1;
      endcase
   end

   assign bus.in_ready = !rst && open;
   assign accept       = bus.in_valid && bus.in_ready;

   assign load[0] = accept && (sel == DST_A);
   assign load[1] = accept && (sel == DST_B);
   assign load[2] = accept && (sel == DST_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         drops <= '0;
      end else if (accept && sel == DST_DROP && drops != 8'hFF) begin
         drops <= drops + 8'd1;
      end
   end

   assign bus.drop_cnt = drops;

   vec_out_slot #(.N(N), .M(M)) u_a (
      .clk   (clk),
      .rst   (rst),
      .load  (load[0]),
      .ready (bus.a_ready),
      .data  (bus.in_data),
      .valid (bus.a_valid),
      .q     (bus.a_data)
   );

   vec_out_slot #(.N(N), .M(M)) u_b (
      .clk   (clk),
      .rst   (rst),
      .load  (load[1]),
      .ready (bus.b_ready),
      .data  (bus.in_data),
      .valid (bus.b_valid),
      .q     (bus.b_data)
   );

   vec_out_slot #(.N(N), .M(M)) u_c (
      .clk   (clk),
      .rst   (rst),
      .load  (load[2]),
      .ready (bus.c_ready),
      .data  (bus.in_data),
      .valid (bus.c_valid),
      .q     (bus.c_data)
   );
endmodule

// File: tb/tb_vec_demux_router.sv
// Bench for vec_demux_router: directed steps plus random traffic
// against a queue-per-port reference model.
module tb_vec_demux_router;
   import vec_demux_router_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   vec_demux_router_if #(.N(8), .M(16)) bus ();

   vec_demux_router #(.N(8), .M(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference: a port holds at most one queued vector at a time.
   vec_t mq0[$];
   vec_t mq1[$];
   vec_t mq2[$];
   vec_t last [3];
   int   mdrop;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int p);
      if (p == 0) return mq0.size();
      if (p == 1) return mq1.size();
      return mq2.size();
   endfunction

   function automatic vec_t exp_data(input int p);
      if (qsize(p) == 0) return last[p];
      if (p == 0) return mq0[0];
      if (p == 1) return mq1[0];
      return mq2[0];
   endfunction

   function automatic vec_t rnd_vec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_outputs();
      chk("a_valid", 128'(bus.a_valid), 128'(qsize(0) != 0));
      chk("b_valid", 128'(bus.b_valid), 128'(qsize(1) != 0));
      chk("c_valid", 128'(bus.c_valid), 128'(qsize(2) != 0));
      chk("a_data", bus.a_data, exp_data(0));
      chk("b_data", bus.b_data, exp_data(1));
      chk("c_data", bus.c_data, exp_data(2));
      chk("drop_cnt", 128'(bus.drop_cnt), 128'(mdrop));
   endtask

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      mq2.delete();
      for (int p = 0; p < 3; p++) last[p] = '0;
      mdrop = 0;
   endtask

   task automatic drive(input bit v, input logic [1:0] s,
                        input vec_t d, input logic [2:0] r);
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = r[0];
      bus.b_ready  = r[1];
      bus.c_ready  = r[2];
   endtask

   task automatic cyc(input bit v, input logic [1:0] s,
                      input vec_t d, input logic [2:0] r);
      bit exp_rdy;
      bit acc;
      drive(v, s, d, r);
      #1;
      exp_rdy = (s == 2'b11) || (qsize(int'(s)) == 0) || r[s];
      chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (r[0] && mq0.size() != 0) void'(mq0.pop_front());
      if (r[1] && mq1.size() != 0) void'(mq1.pop_front());
      if (r[2] && mq2.size() != 0) void'(mq2.pop_front());
      if (acc) begin
         unique case (s)
            2'b00: mq0.push_back(d);
            2'b01: mq1.push_back(d);
            2'b10: mq2.push_back(d);
            2'b11: if (mdrop < 255) mdrop++;
         endcase
      end
      if (mq0.size() != 0) last[0] = mq0[0];
      if (mq1.size() != 0) last[1] = mq1[0];
      if (mq2.size() != 0) last[2] = mq2[0];
      #1;
      check_outputs();
   endtask

   task automatic rst_cyc(input bit v, input logic [2:0] r);
      rst = 1'b1;
      drive(v, 2'b00, rnd_vec(), r);
      #1;
      chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clk);
      model_reset();
      #1;
      check_outputs();
   endtask

   initial begin
      vec_t v0;
      vec_t b1;
      vec_t b2;
      model_reset();

      rst_cyc(1'b1, 3'b111);
      rst_cyc(1'b0, 3'b111);
      rst = 1'b0;

      // First accept right after reset release.
      v0 = rnd_vec();
      v0[0] = 8'h11;
      cyc(1'b1, 2'b00, v0, 3'b001);
      chk("a_lane0", 128'(bus.a_data[0]), 128'(8'h11));
      chk("a_valid_first", 128'(bus.a_valid), 128'(1));
      cyc(1'b0, 2'b00, rnd_vec(), 3'b111);

      // B stalled: second vector waits for b_ready.
      b1 = rnd_vec();
      b2 = rnd_vec();
      cyc(1'b1, 2'b01, b1, 3'b101);
      cyc(1'b1, 2'b01, b2, 3'b101);
      cyc(1'b1, 2'b01, b2, 3'b101);
      chk("b_hold", bus.b_data, b1);
      cyc(1'b1, 2'b01, b2, 3'b111);
      chk("b_second", bus.b_data, b2);
      cyc(1'b0, 2'b01, rnd_vec(), 3'b111);

      // A stalled does not block C.
      cyc(1'b1, 2'b00, rnd_vec(), 3'b000);
      cyc(1'b1, 2'b10, rnd_vec(), 3'b000);
      chk("c_past_a", 128'(bus.c_valid), 128'(1));
      cyc(1'b0, 2'b00, rnd_vec(), 3'b111);

      // Drops saturate.
      for (int i = 0; i < 260; i++) cyc(1'b1, 2'b11, rnd_vec(), 3'b111);
      chk("drop_sat", 128'(bus.drop_cnt), 128'(255));

      // Streaming B at full rate.
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'b01, rnd_vec(), 3'b111);
      cyc(1'b0, 2'b01, rnd_vec(), 3'b111);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 2'($urandom),
             rnd_vec(), 3'($urandom));
      end

      // Reset while A and C hold vectors.
      cyc(1'b0, 2'b00, rnd_vec(), 3'b111);
      cyc(1'b1, 2'b00, rnd_vec(), 3'b000);
      cyc(1'b1, 2'b10, rnd_vec(), 3'b000);
      cyc(1'b1, 2'b11, rnd_vec(), 3'b000);
      chk("pre_rst_a", 128'(bus.a_valid), 128'(1));
      chk("pre_rst_c", 128'(bus.c_valid), 128'(1));
      rst_cyc(1'b1, 3'b000);
      chk("rst_a_data", bus.a_data, 128'(0));
      rst_cyc(1'b1, 3'b000);
      rst = 1'b0;
      cyc(1'b1, 2'b10, rnd_vec(), 3'b000);
      cyc(1'b0, 2'b10, rnd_vec(), 3'b111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
